mips_regfile: RTL



---
 rtl/mips_pkg.sv | 13 +
 rtl/mips_regfile_reg_cell.sv | 37 +++
 rtl/mips_regfile.sv | 80 ++++++++
 3 files changed

// File: rtl/mips_pkg.sv
// Shared constants for the MIPS register file: data/address widths and the
// architectural register numbers referenced by the datapath and bench.
package mips_pkg;

    localparam int DATA_W   = 32;
    localparam int ADDR_W   = 5;
    localparam int NUM_REGS = 1 << ADDR_W;

    localparam logic [4:0] REG_ZERO = 5'd0;
    localparam logic [4:0] REG_SP   = 5'd29;
    localparam logic [4:0] REG_RA   = 5'd31;

endpackage : mips_pkg

// File: rtl/mips_regfile_reg_cell.sv
// One architectural register: DATA_W bits with synchronous active-high clear
// and a write enable. Clear wins over a simultaneous write.
module reg_cell #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              we,
    input  logic [DATA_W-1:0] d,
    output logic [DATA_W-1:0] q
);

    logic [DATA_W-1:0] data_d;
    logic [DATA_W-1:0] data_q;

    // Next value: load on write enable, otherwise hold.
    always_comb begin
        data_d = data_q;
        if (we) begin
            data_d = d;
        end else begin
            data_d = data_q;
        end
    end

    // Storage flop; reset has priority over the load path.
    always_ff @(posedge clk) begin
        if (reset) begin
            data_q <= '0;
        end else begin
            data_q <= data_d;
        end
    end

    assign q = data_q;

endmodule : reg_cell

// File: rtl/mips_regfile.sv
// 32 x DATA_W MIPS register file: two combinational read ports with
// write-to-read bypass, one clocked write port, $0 hard-wired to zero.
module mips_regfile #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              reg_write,
    input  logic [ADDR_W-1:0] write_addr,
    input  logic [DATA_W-1:0] write_data,
    input  logic [ADDR_W-1:0] read_addr1,
    input  logic [ADDR_W-1:0] read_addr2,
    output logic [DATA_W-1:0] read_data1,
    output logic [DATA_W-1:0] read_data2
);

    import mips_pkg::*;

    localparam int NREGS = 1 << ADDR_W;

    logic [NREGS-1:1]  we_s;
    logic [DATA_W-1:0] regs_s [NREGS];
    logic [DATA_W-1:0] stored1_s;
    logic [DATA_W-1:0] stored2_s;

    // $0 resolves to zero, a matching in-flight write is forwarded, else storage.
    function automatic logic [DATA_W-1:0] read_port(
        input logic [ADDR_W-1:0] ra,
        input logic [DATA_W-1:0] stored,
        input logic              wr_en,
        input logic [ADDR_W-1:0] wr_addr,
        input logic [DATA_W-1:0] wr_data
    );
        logic [DATA_W-1:0] result;
        if (ra == ADDR_W'(REG_ZERO)) begin
            result = '0;
        end else if (wr_en && (wr_addr == ra)) begin
            result = wr_data;
        end else begin
            result = stored;
        end
        return result;
    endfunction

    assign regs_s[0] = '0;

    // One-hot write decode; slot 0 has no storage so it is never generated.
    always_comb begin
        we_s = '0;
        for (int i = 1; i < NREGS; i++) begin
            if (reg_write && (write_addr == ADDR_W'(i))) begin
                we_s[i] = 1'b1;
            end else begin
                we_s[i] = 1'b0;
            end
        end
    end

    for (genvar g = 1; g < NREGS; g++) begin : g_cell
        reg_cell #(
            .DATA_W (DATA_W)
        ) u_cell (
            .clk   (clk),
            .reset (reset),
            .we    (we_s[g]),
            .d     (write_data),
            .q     (regs_s[g])
        );
    end

    // Read selection followed by bypass and zero override, per port.
    always_comb begin
        stored1_s  = regs_s[read_addr1];
        stored2_s  = regs_s[read_addr2];
        read_data1 = read_port(read_addr1, stored1_s, reg_write, write_addr, write_data);
        read_data2 = read_port(read_addr2, stored2_s, reg_write, write_addr, write_data);
    end

endmodule : mips_regfile
